mc_main_controller_ext: RTL
===========================

Name: mc_main_controller_ext

Overview:
Parametrised successor to the multicycle MIPS main controller FSM.
- Decodes a 6-bit opcode and sequences the Fetch/Decode/Execute/Memory/Writeback states.
- Drives every datapath control strobe directly, instead of exposing only the state code.
- Adds feature-gated addi, j and bne support, a memory-ready stall handshake, illegal-opcode trapping and a retired-instruction counter.
- Sits in control_unit, between the instruction register opcode field and the multicycle datapath.

Parameters:
ENABLE_ADDI, 1, 1 = addi (001000) supported; 0 = addi is illegal
ENABLE_JUMP, 1, 1 = j (000010) supported; 0 = j is illegal
ENABLE_BNE, 1, 1 = bne (000101) supported; 0 = bne is illegal
TRAP_ON_ILLEGAL, 1, 1 = illegal opcode enters TRAP; 0 = illegal opcode returns to FETCH (treated as nop)
CNT_W, 16, width of the retired-instruction counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
opcode  in  6  instr[31:26] from the instruction register
mem_ready  in  1  memory completes the current access this cycle
state  out  4  current state code
mem_req  out  1  memory access request
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
pc_write  out  1  unconditional PC load
branch  out  1  beq PC-load qualifier (zero)
branch_ne  out  1  bne PC-load qualifier (!zero)
pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 B, 01 const 4, 10 sign-extended imm, 11 imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
reg_write  out  1  register file write
illegal  out  1  high while in TRAP
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (async, any state, mid-instruction included) forces state = FETCH (0), retired = 0. All strobes follow state decode, so every output shows its FETCH value during reset.
- Moore outputs, with two exceptions: ir_write and pc_write in FETCH are ANDed with mem_ready.
- State codes, non-default outputs and next state (all unlisted outputs are 0):
  - 0 FETCH: mem_req = 1, alu_src_b = 01, ir_write/pc_write = mem_ready. Next = DECODE if mem_ready, else stay.
  - 1 DECODE: alu_src_b = 11. Next by opcode:
    - lw/sw (100011/101011) -> MEMADR
    - R-type (000000) -> EXECUTE
    - beq (000100) -> BEQ
    - addi -> ADDIEX
    - j -> JEX
    - bne -> BNE
    - anything else (including a disabled feature) -> TRAP, or FETCH when TRAP_ON_ILLEGAL = 0
  - 2 MEMADR: alu_src_a = 1, alu_src_b = 10. Next = MEMRD for lw, MEMWR for sw. Opcode is sampled again here; the IR is stable.
  - 3 MEMRD: mem_req = 1, iord = 1. Next = MEMWB if mem_ready, else stay.
  - 4 MEMWB: mem_to_reg = 1, reg_write = 1. Next = FETCH.
  - 5 MEMWR: mem_req = 1, iord = 1, mem_write = 1 for every cycle in the state. Next = FETCH if mem_ready, else stay.
  - 6 EXECUTE: alu_src_a = 1, alu_op = 10. Next = ALUWB.
  - 7 ALUWB: reg_dst = 1, reg_write = 1. Next = FETCH.
  - 8 BEQ: alu_src_a = 1, alu_op = 01, pc_src = 01, branch = 1. Next = FETCH.
  - 9 ADDIEX: alu_src_a = 1, alu_src_b = 10. Next = ADDIWB.
  - 10 ADDIWB: reg_write = 1. Next = FETCH.
  - 11 JEX: pc_src = 10, pc_write = 1. Next = FETCH.
  - 12 BNE: as BEQ, but branch = 0 and branch_ne = 1. Next = FETCH.
  - 13 TRAP: illegal = 1. Stays until reset.
  - Codes 14 and 15 are unreachable; if entered, next = FETCH.
- retired counter:
  - Increments by 1 on each clock edge that leaves MEMWB, ALUWB, ADDIWB, BEQ, BNE or JEX, and on leaving MEMWR with mem_ready = 1.
  - Does not increment for an illegal opcode, or for the DECODE -> FETCH skip when TRAP_ON_ILLEGAL = 0.
  - Wraps modulo 2^CNT_W.
- Cycles per instruction with mem_ready held high: lw 5, sw 4, R 4, addi 4, beq 3, bne 3, j 3. Each mem_ready = 0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.

Test Plan:
- Reset mid-sequence: assert reset for 3 ns in EXECUTE, asynchronous to clock -> state = 0 immediately, retired = 0, FETCH strobes shown.
- mem_ready = 1, sequence lw, sw, R, beq, addi, j, bne -> states 0,1,2,3,4 / 0,1,2,5 / 0,1,6,7 / 0,1,8 / 0,1,9,10 / 0,1,11 / 0,1,12; every strobe matches its table; retired = 7 after the bne.
- Stall: lw with mem_ready = 0 for 2 cycles in FETCH and 3 cycles in MEMRD -> state holds; ir_write = pc_write = 0 while stalled; total 10 cycles; retired increments exactly once.
- sw stall: mem_write and mem_req held at 1 for all 4 MEMWR cycles (mem_ready low for 3) -> single retire on the exit edge.
- Illegal: opcode 111111 -> TRAP (13), illegal = 1, state stuck for 10 cycles. With ENABLE_JUMP = 0, j -> TRAP. With TRAP_ON_ILLEGAL = 0, 111111 -> 0,1,0 and retired unchanged.
- Wrap: CNT_W = 2, five R-type instructions -> retired sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/mc_main_controller_ext_if.sv
// rtl/mc_main_controller_ext_if.sv - control bus between the main controller and the multicycle datapath
interface mc_main_controller_ext_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic [3:0]       state;
  logic             mem_req;
  logic             iord;
  logic             mem_write;
  logic             ir_write;
  logic             pc_write;
  logic             branch;
  logic             branch_ne;
  logic [1:0]       pc_src;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output state, mem_req, iord, mem_write, ir_write, pc_write, branch, branch_ne,
           pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
           illegal, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  state, mem_req, iord, mem_write, ir_write, pc_write, branch, branch_ne,
           pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
           illegal, retired
  );
endinterface

// File: rtl/mc_main_controller_ext.sv
// rtl/mc_main_controller_ext.sv - multicycle MIPS main controller FSM with direct strobes and retire counter
module mc_main_controller_ext #(
  parameter bit ENABLE_ADDI     = 1'b1,
  parameter bit ENABLE_JUMP     = 1'b1,
  parameter bit ENABLE_BNE      = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  mc_main_controller_ext_if.master    bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNE     = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  logic       mem_req, iord, mem_write, ir_write, pc_write, branch, branch_ne;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal;
  logic [1:0] pc_src, alu_src_b, alu_op;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire)
        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // IR and PC only load on the cycle memory actually returns the word
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready)
          state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (bus.opcode == OP_LW || bus.opcode == OP_SW)
          state_d = S_MEMADR;
        else if (bus.opcode == OP_RTYPE)
          state_d = S_EXECUTE;
        else if (bus.opcode == OP_BEQ)
          state_d = S_BEQ;
        else if (ENABLE_ADDI && bus.opcode == OP_ADDI)
          state_d = S_ADDIEX;
        else if (ENABLE_JUMP && bus.opcode == OP_J)
          state_d = S_JEX;
        else if (ENABLE_BNE && bus.opcode == OP_BNE)
          state_d = S_BNE;
        else
          state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (bus.mem_ready)
          state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JEX: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BNE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch_ne = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign bus.state      = state_q;
  assign bus.mem_req    = mem_req;
  assign bus.iord       = iord;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.branch     = branch;
  assign bus.branch_ne  = branch_ne;
  assign bus.pc_src     = pc_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.illegal    = illegal;
  assign bus.retired    = retired_q;
endmodule
